// File: rtl/ace_rd_arbiter.sv
// Two-requester ACE read-port arbiter (IFU = 0, LSU = 1) with per-requester outstanding caps and local RACK.
// Define ACE_RD_ARB_FIXED_PRIO_EN for fixed priority to requester 0; round-robin otherwise.
module ace_rd_arbiter #(
    parameter int ID_WIDTH          = 4,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int ACE_AXADDR_WIDTH  = 32,
    parameter int ACE_AXLEN_WIDTH   = 8,
    parameter int ACE_AXSIZE_WIDTH  = 3,
    parameter int ACE_AXBURST_WIDTH = 2,
    parameter int ACE_AXPROT_WIDTH  = 3,
    parameter int ACE_ARSNOOP_WIDTH = 4,
    parameter int ACE_AXDOMAIN_WIDTH = 2,
    parameter int ACE_XDATA_WIDTH   = 64,
    parameter int ACE_RRESP_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      s_arvalid,
    output logic [1:0]                      s_arready,
    input  logic [2*ID_WIDTH-1:0]           s_arid,
    input  logic [2*ACE_AXADDR_WIDTH-1:0]   s_araddr,
    input  logic [2*ACE_AXLEN_WIDTH-1:0]    s_arlen,
    input  logic [2*ACE_AXSIZE_WIDTH-1:0]   s_arsize,
    input  logic [2*ACE_AXBURST_WIDTH-1:0]  s_arburst,
    input  logic [2*ACE_AXPROT_WIDTH-1:0]   s_arprot,
    input  logic [2*ACE_ARSNOOP_WIDTH-1:0]  s_arsnoop,
    input  logic [2*ACE_AXDOMAIN_WIDTH-1:0] s_ardomain,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ID_WIDTH:0]               m_arid,
    output logic [ACE_AXADDR_WIDTH-1:0]     m_araddr,
    output logic [ACE_AXLEN_WIDTH-1:0]      m_arlen,
    output logic [ACE_AXSIZE_WIDTH-1:0]     m_arsize,
    output logic [ACE_AXBURST_WIDTH-1:0]    m_arburst,
    output logic [ACE_AXPROT_WIDTH-1:0]     m_arprot,
    output logic [ACE_ARSNOOP_WIDTH-1:0]    m_arsnoop,
    output logic [ACE_AXDOMAIN_WIDTH-1:0]   m_ardomain,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [ID_WIDTH:0]               m_rid,
    input  logic [ACE_XDATA_WIDTH-1:0]      m_rdata,
    input  logic [ACE_RRESP_WIDTH-1:0]      m_rresp,
    input  logic                            m_rlast,
    output logic [1:0]                      s_rvalid,
    input  logic [1:0]                      s_rready,
    output logic [ID_WIDTH-1:0]             s_rid,
    output logic [ACE_XDATA_WIDTH-1:0]      s_rdata,
    output logic [ACE_RRESP_WIDTH-1:0]      s_rresp,
    output logic                            s_rlast,
    output logic                            m_rack,
    output logic                            err
);
    // state | meaning
    // IDLE  | no request on the master port; arbitrate and capture a winner
    // HOLD  | captured request presented on m_ar*, waiting for m_arready
    typedef enum logic {IDLE, HOLD} state_t;

    localparam int CW = 4;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    state_t                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic [1:0][CW-1:0]     cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   rack_q;
    logic [1:0]             elig;
    logic                   pick;
    logic                   cap;
    logic                   ar_done;
    logic                   r_last_hs;
    logic                   sel;

`ifndef ACE_RD_ARB_FIXED_PRIO_EN
    logic                   rr_q, rr_d;
`endif

    assign elig[0] = s_arvalid[0] && (cnt_q[0] < MAX_C);
    assign elig[1] = s_arvalid[1] && (cnt_q[1] < MAX_C);

`ifdef ACE_RD_ARB_FIXED_PRIO_EN
    assign pick = !elig[0];
`else
    // rr_q names the requester that wins a tie
    assign pick = (elig[0] && elig[1]) ? rr_q : elig[1];
    assign rr_d = cap ? ~pick : rr_q;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        s_arready = 2'b00;
        cap       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    s_arready[pick] = 1'b1;
                    grant_d         = pick;
                    cap             = 1'b1;
                    state_d         = HOLD;
                end
            end
            HOLD: begin
                if (m_arready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_arvalid = (state_q == HOLD);
    assign ar_done   = m_arvalid && m_arready;

    assign sel       = m_rid[ID_WIDTH];
    assign s_rvalid  = sel ? {m_rvalid, 1'b0} : {1'b0, m_rvalid};
    assign m_rready  = s_rready[sel];
    assign s_rid     = m_rid[ID_WIDTH-1:0];
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign r_last_hs = m_rvalid && m_rready && m_rlast;
    assign m_rack    = rack_q;
    assign err       = err_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic inc, dec;
            inc = ar_done && (grant_q == 1'(i));
            // a last beat for a requester with nothing outstanding is an error, not an underflow
            dec = r_last_hs && (sel == 1'(i)) && (cnt_q[i] != '0);
            case ({inc, dec})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        err_d = err_q || (m_rvalid && (cnt_q[sel] == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rack_q     <= 1'b0;
            m_arid     <= '0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arsize   <= '0;
            m_arburst  <= '0;
            m_arprot   <= '0;
            m_arsnoop  <= '0;
            m_ardomain <= '0;
`ifndef ACE_RD_ARB_FIXED_PRIO_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rack_q  <= r_last_hs;
`ifndef ACE_RD_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
            if (cap) begin
                m_arid     <= {pick, pick ? s_arid[2*ID_WIDTH-1:ID_WIDTH] : s_arid[ID_WIDTH-1:0]};
                m_araddr   <= pick ? s_araddr[2*ACE_AXADDR_WIDTH-1:ACE_AXADDR_WIDTH]
                                   : s_araddr[ACE_AXADDR_WIDTH-1:0];
                m_arlen    <= pick ? s_arlen[2*ACE_AXLEN_WIDTH-1:ACE_AXLEN_WIDTH]
                                   : s_arlen[ACE_AXLEN_WIDTH-1:0];
                m_arsize   <= pick ? s_arsize[2*ACE_AXSIZE_WIDTH-1:ACE_AXSIZE_WIDTH]
                                   : s_arsize[ACE_AXSIZE_WIDTH-1:0];
                m_arburst  <= pick ? s_arburst[2*ACE_AXBURST_WIDTH-1:ACE_AXBURST_WIDTH]
                                   : s_arburst[ACE_AXBURST_WIDTH-1:0];
                m_arprot   <= pick ? s_arprot[2*ACE_AXPROT_WIDTH-1:ACE_AXPROT_WIDTH]
                                   : s_arprot[ACE_AXPROT_WIDTH-1:0];
                m_arsnoop  <= pick ? s_arsnoop[2*ACE_ARSNOOP_WIDTH-1:ACE_ARSNOOP_WIDTH]
                                   : s_arsnoop[ACE_ARSNOOP_WIDTH-1:0];
                m_ardomain <= pick ? s_ardomain[2*ACE_AXDOMAIN_WIDTH-1:ACE_AXDOMAIN_WIDTH]
                                   : s_ardomain[ACE_AXDOMAIN_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Bench for ace_rd_arbiter: directed scenarios plus a randomized phase against a transaction-level model.
module tb_ace_rd_arbiter;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  s_arvalid = '0;
    logic [1:0]  s_arready;
    logic [7:0]  s_arid = '0;
    logic [63:0] s_araddr = '0;
    logic [15:0] s_arlen = '0;
    logic [5:0]  s_arsize = '0;
    logic [3:0]  s_arburst = '0;
    logic [5:0]  s_arprot = '0;
    logic [7:0]  s_arsnoop = '0;
    logic [3:0]  s_ardomain = '0;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [4:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [2:0]  m_arprot;
    logic [3:0]  m_arsnoop;
    logic [1:0]  m_ardomain;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [4:0]  m_rid = '0;
    logic [63:0] m_rdata = '0;
    logic [3:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready = '0;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [3:0]  s_rresp;
    logic        s_rlast;
    logic        m_rack;
    logic        err;

    ace_rd_arbiter #(.ID_WIDTH(4), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arprot(s_arprot),
        .s_arsnoop(s_arsnoop), .s_ardomain(s_ardomain),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arprot(m_arprot),
        .m_arsnoop(m_arsnoop), .m_ardomain(m_ardomain),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_rack(m_rack), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the pending master-side request, per-requester in-flight totals,
    // which requester gets the next tie, and the sticky error / ack expectations.
    logic [58:0] pend_pl;
    bit          pend_v;
    int          pend_g;
    int          cnt[2];
    int          prio;
    bit          err_m;
    bit          rack_m;
    int          grants[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_v = 0; pend_g = 0; pend_pl = '0;
        cnt[0] = 0; cnt[1] = 0; prio = 0;
        err_m = 0; rack_m = 0;
    endtask

    function automatic int winner(input bit e0, input bit e1);
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
        return e0 ? 0 : 1;
`else
        if (e0 && e1) return prio;
        return e0 ? 0 : 1;
`endif
    endfunction

    function automatic logic [58:0] req_payload(input int r);
        logic [58:0] p;
        p = {1'(r), s_arid[r*4 +: 4], s_araddr[r*32 +: 32], s_arlen[r*8 +: 8], s_arsize[r*3 +: 3],
             s_arburst[r*2 +: 2], s_arprot[r*3 +: 3], s_arsnoop[r*4 +: 4], s_ardomain[r*2 +: 2]};
        return p;
    endfunction

    task automatic check_outputs();
        bit e0, e1;
        logic [1:0] exp_rdy;
        int s;
        e0 = s_arvalid[0] && cnt[0] < MAXO;
        e1 = s_arvalid[1] && cnt[1] < MAXO;
        exp_rdy = 2'b00;
        if (!pend_v && (e0 || e1)) exp_rdy[winner(e0, e1)] = 1'b1;
        chk("s_arready", 64'(s_arready), 64'(exp_rdy));
        chk("m_arvalid", 64'(m_arvalid), 64'(pend_v));
        if (pend_v)
            chk("ar_payload", 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arprot,
                                   m_arsnoop, m_ardomain}), 64'(pend_pl));
        s = int'(m_rid[4]);
        chk("s_rvalid", 64'(s_rvalid), m_rvalid ? 64'(1 << s) : 64'd0);
        chk("m_rready", 64'(m_rready), 64'(s_rready[s]));
        chk("s_rid", 64'(s_rid), 64'(m_rid[3:0]));
        chk("s_rdata", s_rdata, m_rdata);
        chk("m_rack", 64'(m_rack), 64'(rack_m));
        chk("err", 64'(err), 64'(err_m));
    endtask

    task automatic update_model();
        int old[2];
        bit e0, e1, hs;
        int g, s;
        old = cnt;
        e0 = s_arvalid[0] && old[0] < MAXO;
        e1 = s_arvalid[1] && old[1] < MAXO;
        if (!pend_v) begin
            if (e0 || e1) begin
                g = winner(e0, e1);
                pend_pl = req_payload(g);
                pend_v = 1; pend_g = g; prio = 1 - g;
                grants.push_back(g);
            end
        end else if (m_arready) begin
            cnt[pend_g]++;
            pend_v = 0;
        end
        s = int'(m_rid[4]);
        hs = m_rvalid && s_rready[s];
        if (m_rvalid && old[s] == 0) err_m = 1;
        rack_m = hs && m_rlast;
        if (hs && m_rlast && old[s] > 0) cnt[s]--;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic randomize_payload();
        s_arid     = 8'($urandom);
        s_araddr   = {$urandom, $urandom};
        s_arlen    = 16'($urandom);
        s_arsize   = 6'($urandom);
        s_arburst  = 4'($urandom);
        s_arprot   = 6'($urandom);
        s_arsnoop  = 8'($urandom);
        s_ardomain = 4'($urandom);
        m_rdata    = {$urandom, $urandom};
        m_rresp    = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        s_rready  = 2'b11;
        while ((cnt[0] + cnt[1] > 0 || pend_v) && n < 200) begin
            m_rvalid = (cnt[0] + cnt[1] > 0);
            m_rid    = (cnt[0] > 0) ? 5'h02 : 5'h15;
            m_rlast  = 1'b1;
            step();
            n++;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
        if (n >= 200) begin
            checks++; errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", cnt[0] + cnt[1]);
        end
        step();
    endtask

    initial begin
        logic [31:0] held_addr;
        int exp_g[8];
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_payload", 64'({m_arid, m_araddr, m_arlen}), 64'd0);
        step();

        // Single read from requester 1
        s_arvalid = 2'b10; s_arid = 8'h30; s_araddr = {32'h8000_0040, 32'h0}; s_arlen = 16'h0;
        step();
        s_arvalid = 2'b00;
        chk("t1_arid", 64'(m_arid), 64'h13);
        chk("t1_araddr", 64'(m_araddr), 64'h8000_0040);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 5'h13; m_rlast = 1'b1; s_rready = 2'b10;
        #1;
        chk("t1_s_rvalid", 64'(s_rvalid), 64'h2);
        chk("t1_s_rid", 64'(s_rid), 64'h3);
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("t1_rack", 64'(m_rack), 64'd1);
        step();
        chk("t1_rack_end", 64'(m_rack), 64'd0);

        // Contention, both requesters always requesting
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        grants.delete();
        randomize_payload();
        s_arvalid = 2'b11; m_arready = 1'b1;
        repeat (16) step();
        chk("cont_ngrants", 64'(grants.size()), 64'd8);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            chk($sformatf("cont_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
        drain();

        // Outstanding cap on requester 0
        s_arvalid = 2'b01; m_arready = 1'b1;
        repeat (8) step();
        repeat (3) begin
            #1 chk("cap_block", 64'(s_arready), 64'd0);
            step();
        end
        m_rvalid = 1'b1; m_rid = 5'h00; m_rlast = 1'b1; s_rready = 2'b01;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 chk("cap_regrant", 64'(s_arready), 64'd1);
        step();

        // Backpressure on AR, and R backpressure from requester 0
        m_arready = 1'b0; s_arvalid = 2'b11;
        held_addr = m_araddr;
        repeat (5) begin
            randomize_payload();
            m_rvalid = 1'b1; m_rid = 5'h00; m_rlast = 1'b0; s_rready = 2'b10;
            #1;
            chk("bp_m_rready", 64'(m_rready), 64'd0);
            chk("bp_arready", 64'(s_arready), 64'd0);
            chk("bp_arvalid", 64'(m_arvalid), 64'd1);
            chk("bp_araddr", 64'(m_araddr), 64'(held_addr));
            step();
        end
        m_rvalid = 1'b0; m_arready = 1'b1; s_arvalid = 2'b00;
        step();
        drain();

        // Randomized traffic; R beats only for requesters with reads in flight
        for (int c = 0; c < 400; c++) begin
            int r;
            randomize_payload();
            s_arvalid = 2'($urandom);
            m_arready = ($urandom_range(0, 9) < 7);
            s_rready  = 2'($urandom);
            m_rlast   = 1'($urandom);
            r = $urandom_range(0, 1);
            if (cnt[r] == 0) r = 1 - r;
            m_rvalid  = (cnt[r] > 0) && 1'($urandom);
            m_rid     = {1'(r), 4'($urandom)};
            step();
        end
        drain();

        // Stray R beat sets the sticky error
        m_rvalid = 1'b1; m_rid = 5'h10; m_rlast = 1'b1; s_rready = 2'b11;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("err_set", 64'(err), 64'd1);
        repeat (3) step();
        chk("err_sticky", 64'(err), 64'd1);

        // Asynchronous reset mid-transaction
        s_arvalid = 2'b01; m_arready = 1'b0;
        step();
        s_arvalid = 2'b00;
        chk("rst_pre_arvalid", 64'(m_arvalid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_rack", 64'(m_rack), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        m_rvalid = 1'b1; m_rid = 5'h00; m_rlast = 1'b1; s_rready = 2'b11;
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("post_rst_err", 64'(err), 64'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ace_rd_arbiter.md
# ace_rd_arbiter

Shares one ACE read master port (AR/R/RACK) between two requesters: requester 0 is the IFU line-fill path, requester 1 the LSU fill path. It arbitrates AR requests, tags each with the requester index in the ID MSB, and routes R beats back by that bit. It caps outstanding reads per requester and generates RACK itself. It sits between the cores' cache controllers and the interconnect.

## Interface
Parameters:
- ID_WIDTH, 4: requester-side ARID/RID width; master-side width is ID_WIDTH+1.
- MAX_OUTSTANDING, 4: maximum in-flight reads per requester (1..15).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- s_arvalid  input  2  per-requester AR valid.
- s_arready  output  2  per-requester AR ready.
- s_arid  input  2×ID_WIDTH  per-requester ARID.
- s_araddr  input  2×ACE_AXADDR_WIDTH  per-requester address.
- s_arlen, s_arsize, s_arburst, s_arprot, s_arsnoop, s_ardomain  input  2×(respective ACE_*_WIDTH)  per-requester AR attributes.
- m_arvalid  output  1  master AR valid.
- m_arready  input  1  master AR ready.
- m_arid  output  ID_WIDTH+1  {requester index, s_arid}.
- m_araddr, m_arlen, m_arsize, m_arburst, m_arprot, m_arsnoop, m_ardomain  output  (ACE widths)  registered payload of the granted request.
- m_rvalid  input  1  master R valid.
- m_rready  output  1  master R ready.
- m_rid  input  ID_WIDTH+1  master RID.
- m_rdata  input  ACE_XDATA_WIDTH  read data, fanned out to both requesters.
- m_rresp  input  ACE_RRESP_WIDTH  response, fanned out.
- m_rlast  input  1  last beat, fanned out.
- s_rvalid  output  2  per-requester R valid.
- s_rready  input  2  per-requester R ready.
- s_rid  output  ID_WIDTH  m_rid[ID_WIDTH-1:0].
- m_rack  output  1  ACE read acknowledge.
- err  output  1  sticky protocol-error flag.

## Operation
- AR FSM, two states.
  - IDLE: m_arvalid=0.
    - A requester is eligible when its s_arvalid=1 and its count < MAX_OUTSTANDING.
    - Grant goes to one eligible requester: round-robin, or fixed priority (see Configuration).
    - s_arready[g]=1 combinationally in the same cycle.
    - Payload is captured into the output registers; next state is HOLD.
    - If no requester is eligible, stay in IDLE.
  - HOLD: m_arvalid=1 with the payload held stable.
    - s_arready=0 for both requesters.
    - On m_arready, count[g] increments and the FSM returns to IDLE.
- Round-robin pointer:
  - Updates only on a grant, to point at the other requester.
  - Reset value: requester 0 has priority.
- R routing (combinational):
  - sel = m_rid[ID_WIDTH].
  - s_rvalid[sel] = m_rvalid, and the other requester's s_rvalid = 0.
  - m_rready = s_rready[sel].
- On m_rvalid & m_rready & m_rlast, count[sel] decrements.
- Simultaneous increment and decrement of the same counter leaves it unchanged.
- m_rack is a one-cycle pulse in the cycle after each last-beat handshake. Back-to-back last beats produce back-to-back pulses.
- err is set (and stays set until reset) when either of these occurs:
  - a last-beat handshake arrives for a requester whose count is 0 (the decrement is suppressed, so the count saturates at 0);
  - m_rvalid is high while count[sel]=0.

## Timing
- Reset values:
  - m_arvalid=0, m_rack=0, err=0, all counts=0, FSM=IDLE, RR pointer=0.
  - Payload registers are cleared to 0.
- AR latency:
  - Requester handshake in cycle N; m_arvalid asserted in cycle N+1.
  - Peak AR throughput is one request per 2 cycles.
- R path has zero latency, with no R-channel storage.
- m_arvalid is never deasserted before m_arready, and the payload does not change while m_arvalid=1 (AXI stability).
- A reset asserted mid-transaction clears all state immediately; in-flight reads are forgotten and later R beats set err.

## Configuration
- ACE_RD_ARB_FIXED_PRIO_EN defined:
  - Requester 0 (IFU) always wins when both requesters are eligible.
  - The RR pointer is removed.
- ACE_RD_ARB_FIXED_PRIO_EN undefined:
  - Round-robin as described above.

## Test plan
- Single read, MAX_OUTSTANDING=4.
  - Stimulus: requester 1 ARID=3, addr 0x8000_0040, arlen=0.
  - Required: m_arid=0x13 one cycle after the handshake. An R beat with rid=0x13 and rlast=1 appears on s_rvalid[1] with s_rid=3. m_rack pulses the next cycle.
- Contention, round-robin build.
  - Stimulus: both requesters hold s_arvalid continuously.
  - Required: grants alternate 0,1,0,1 on consecutive IDLE cycles; m_arvalid is high every other cycle with m_arready=1.
- Contention, ACE_RD_ARB_FIXED_PRIO_EN build.
  - Stimulus: same as the round-robin contention case.
  - Required: requester 0 is granted until its count reaches 4; then requester 1 is granted.
- Outstanding cap.
  - Stimulus: four reads from requester 0 with no R responses.
  - Required: a fifth s_arvalid[0] gets no s_arready. After one rlast handshake, it is granted in the next IDLE cycle.
- Backpressure.
  - Stimulus: m_arready held low for 5 cycles.
  - Required: m_arvalid and the payload stay stable, and neither s_arready asserts. With s_rready[0]=0 during an R beat for requester 0, m_rready=0.
- Error and reset.
  - Stimulus: an R beat with rid MSB=1 while count[1]=0.
  - Required: err=1 and stays 1. Asserting rst low clears err, the counts and m_arvalid within the same cycle.
